// File: rtl/multi_conv_pulse.sv
// ---------------------------------------------------------------------------
// multi_conv_pulse
//
// Purpose:
//   Drives NCH converters with one shared start-of-conversion strobe and waits
//   for every channel to report end-of-conversion. The NCH samples are then
//   reduced to a single W-bit value (mean, max or min, chosen by mode at the
//   capture edge). That value is emitted as a pulse on out lasting exactly
//   that many clock cycles. A programmable low gap follows before the next
//   conversion starts.
//
// Parameters:
//   NCH  number of converter channels (power of 2, 2..16)
//   W    sample / result width (4..16)
//   GAP  low cycles on out after a pulse before soc rises again (0 allowed)
//
// Ports:
//   clock   in   1      system clock, rising-edge active
//   reset   in   1      asynchronous active-high reset
//   soc     out  1      start-of-conversion shared by all channels
//   eoc     in   NCH    end-of-conversion, bit i = channel i
//   x       in   NCH*W  packed samples, channel i at x[i*W +: W]
//   mode    in   2      00 mean, 01 max, 10 min, 11 mean
//   out     out  1      output pulse, high for result cycles
//   result  out  W      last computed result, held until next capture
//   valid   out  1      one-cycle strobe when result updates
// ---------------------------------------------------------------------------
module multi_conv_pulse #(
    parameter int NCH = 4,
    parameter int W   = 8,
    parameter int GAP = 2
) (
    input  logic             clock,
    input  logic             reset,
    output logic             soc,
    input  logic [NCH-1:0]   eoc,
    input  logic [NCH*W-1:0] x,
    input  logic [1:0]       mode,
    output logic             out,
    output logic [W-1:0]     result,
    output logic             valid
);

    localparam int LG = $clog2(NCH);
    localparam int SW = W + LG;
    // Wide enough to hold GAP itself; never narrower than one bit.
    localparam int GW = $clog2(GAP + 2);

    typedef enum logic [2:0] {
        S_START,
        S_CONV,
        S_EVAL,
        S_PULSE,
        S_GAP
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [W-1:0]    pulse_cnt;
    logic [W-1:0]    next_pulse_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [GW-1:0]   next_gap_cnt;
    logic            capture;
    logic [W-1:0]    calc;
    logic [SW-1:0]   sum;
    logic [W-1:0]    max_val;
    logic [W-1:0]    min_val;
    logic [W-1:0]    sample;

    // Reduction of the live sample bus. Only sampled into result on the
    // capture edge, so earlier changes to x or mode have no effect.
    // The accumulator carries LG extra bits so the sum can never overflow.
    always_comb begin
        sum     = '0;
        max_val = '0;
        min_val = '1;
        sample  = '0;
        calc    = '0;
        for (int i = 0; i < NCH; i++) begin
            sample = x[i*W +: W];
            sum    = sum + SW'(sample);
            if (sample > max_val) begin
                max_val = sample;
            end
            if (sample < min_val) begin
                min_val = sample;
            end
        end
        case (mode)
            2'b01:   calc = max_val;
            2'b10:   calc = min_val;
            default: calc = sum[SW-1:LG];
        endcase
    end

    // Next-state logic. START only hands over to CONV once soc has actually
    // been high for a cycle, so soc is never skipped even if eoc is already
    // low. Leaving START requires eoc all low, which also guarantees that a
    // capture can never happen on the START-to-CONV edge.
    always_comb begin
        next_state     = state;
        next_pulse_cnt = pulse_cnt;
        next_gap_cnt   = gap_cnt;
        capture        = 1'b0;
        case (state)
            S_START: begin
                if (soc && (eoc == '0)) begin
                    next_state = S_CONV;
                end
            end
            S_CONV: begin
                if (&eoc) begin
                    capture    = 1'b1;
                    next_state = S_EVAL;
                end
            end
            S_EVAL: begin
                if (result != '0) begin
                    next_state     = S_PULSE;
                    next_pulse_cnt = result;
                end else if (GAP == 0) begin
                    next_state = S_START;
                end else begin
                    next_state   = S_GAP;
                    next_gap_cnt = GW'(GAP);
                end
            end
            S_PULSE: begin
                // The counter holds the number of high cycles still owed,
                // including the current one.
                if (pulse_cnt == W'(1)) begin
                    if (GAP == 0) begin
                        next_state = S_START;
                    end else begin
                        next_state   = S_GAP;
                        next_gap_cnt = GW'(GAP);
                    end
                end else begin
                    next_pulse_cnt = pulse_cnt - W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt == GW'(1)) begin
                    next_state = S_START;
                end else begin
                    next_gap_cnt = gap_cnt - GW'(1);
                end
            end
            default: begin
                next_state = S_START;
            end
        endcase
    end

    // State and registered outputs. Outputs are derived from the state being
    // entered so they line up with the state they describe. Reset keeps soc
    // low; it rises on the first edge after release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_START;
            pulse_cnt <= '0;
            gap_cnt   <= '0;
            soc       <= 1'b0;
            out       <= 1'b0;
            valid     <= 1'b0;
            result    <= '0;
        end else begin
            state     <= next_state;
            pulse_cnt <= next_pulse_cnt;
            gap_cnt   <= next_gap_cnt;
            soc       <= (next_state == S_START);
            out       <= (next_state == S_PULSE);
            valid     <= (next_state == S_EVAL);
            if (capture) begin
                result <= calc;
            end
        end
    end

endmodule

// File: doc/multi_conv_pulse.md
Name: multi_conv_pulse

Overview:
- N-channel acquisition and pulse generator for the converter-interface family.
- Starts all converters together with one shared soc and waits until every eoc has completed the handshake.
- Combines the N samples into one W-bit result, selected at run time as mean, max or min.
- Emits a pulse on out lasting exactly that many clock cycles, then a programmable low gap before the next conversion.

Parameters:
- NCH, 4: number of converter channels; must be a power of 2, range 2..16.
- W, 8: sample and result width, range 4..16.
- GAP, 2: number of clock cycles out stays low after a pulse before soc is raised again; 0 is allowed.

Ports:
- clock  in  1  system clock; all activity on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- soc  out  1  start-of-conversion, shared by all channels.
- eoc  in  NCH  end-of-conversion; bit i belongs to channel i.
- x  in  NCH*W  samples, packed; channel i occupies x[i*W+W-1 : i*W].
- mode  in  2  00 = mean, 01 = max, 10 = min, 11 = reserved (treated as mean).
- out  out  1  output pulse.
- result  out  W  last computed result, held until the next capture.
- valid  out  1  one-cycle strobe when result updates.

Behaviour:
- Reset (asynchronous, effective immediately, any state):
  - soc=0, out=0, valid=0, result=0.
  - Internal counters cleared; state=START.
  - On release, operation begins at the first rising clock edge.
- All outputs are registered.
- States: START, CONV, EVAL, PULSE, GAP.
- START:
  - soc=1, out=0.
  - Go to CONV on the first edge where eoc is all zeros; otherwise stay.
- CONV:
  - soc=0.
  - On the first edge where eoc is all ones: capture mode and x, compute the result, load result, go to EVAL.
  - Mixed eoc patterns keep waiting with no timeout.
  - Changes to mode or x before the capture edge have no effect.
- Arithmetic:
  - mean: sum of NCH samples in an internal W+log2(NCH)-bit accumulator (no overflow possible), right-shifted by log2(NCH), truncated toward zero.
  - max/min: unsigned comparison; ties are irrelevant because only the value is used.
- EVAL (one cycle):
  - valid=1 for exactly this cycle.
  - Pulse counter loaded with result.
  - result != 0: go to PULSE. result == 0: go to GAP with no pulse.
- PULSE:
  - out is high for exactly result consecutive cycles. Maximum is 2^W-1 (255 at W=8).
  - Counter decrements each cycle; exit to GAP after the last high cycle.
- GAP:
  - out=0 for exactly GAP cycles, then START.
  - GAP=0: go directly to START, so out falls and soc rises on the same edge.
- Latency:
  - From the capture edge to out rising: 2 edges (EVAL, then first PULSE cycle).
  - soc is low for the whole of CONV, EVAL, PULSE and GAP.
- Boundaries:
  - eoc already all zero when START is entered: START still lasts at least one cycle, so soc is high for at least one clock.
  - eoc all ones at the same edge as the START-to-CONV transition: no capture on that edge; capture on a later edge in CONV.
  - Reset asserted mid-PULSE: out drops asynchronously; after release no stale pulse continues.

Test Plan:
- Mean, NCH=4, W=8, mode=00, x={10,20,30,41}, normal handshake -> result=25, valid for 1 cycle, out high exactly 25 cycles, then low 2 cycles, then soc=1.
- Max and min on x={200,3,255,17}:
  - mode=01 -> result=255 and out high 255 cycles.
  - mode=10 -> result=3 and out high 3 cycles.
- Zero result, x all 0 -> valid pulses, result=0, out never rises, soc returns high after GAP=2 cycles.
- Staggered eoc, each bit rising on a different cycle, with mode toggled during CONV -> capture only when eoc=4'b1111, using the mode value present at that edge.
- Reset asserted at the 5th cycle of a 40-cycle pulse -> out=0 and soc=0 immediately; after release soc=1 on the first edge and no residual pulse appears.
- GAP=0 build, x all 1 -> out high 1 cycle, and soc rises on the same edge that out falls.
